lifting_block: RTL and testbench
================================

LIFTING_BLOCK -- requirements
Module: lifting_block

Interface
REQ-001 Parameter DW, default 32, sample/output data width (two's complement).
REQ-002 Parameter CF, default 14, fraction bits of lifting coefficients (Q2.CF, 16-bit signed).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 x_in  input  DW  input sample stream, signed.
REQ-006 x_valid  input  1  x_in accepted on rising clk when high.
REQ-007 y2n  output  DW  last accepted even sample x[2n], registered.
REQ-008 y2n_1  output  DW  last accepted odd sample x[2n+1], registered.
REQ-009 y2na  output  DW  predicted even term s1[n] of latest completed pair, registered.
REQ-010 an  output  DW  approximation coefficient a[n-1], registered.
REQ-011 dn  output  DW  detail coefficient d[n-1], registered.
REQ-012 out_valid  output  1  one-cycle pulse; an/dn updated this cycle.

Function
REQ-013 Block SHALL compute a causal Daubechies-4 lifting forward transform, one (an,dn) pair per two accepted samples.
REQ-014 Phase bit SHALL toggle on each accepted sample; first accepted sample after reset is even (x[2n]), next is odd (x[2n+1]).
REQ-015 Even accept SHALL load y2n; no other output changes.
REQ-016 Odd accept SHALL load y2n_1 and compute: s1[n]=x[2n]+M(K0,x[2n+1]); d1[n]=x[2n+1]-M(K1,s1[n])-M(K2,s1[n-1]); s2=s1[n-1]-d1[n]; a[n-1]=M(K3,s2); d[n-1]=M(K4,d1[n-1]).
REQ-017 Constants (Q2.14): K0=28378 (sqrt3), K1=7094 (sqrt3/4), K2=-1098 ((sqrt3-2)/4), K3=8481 ((sqrt3-1)/sqrt2), K4=31651 ((sqrt3+1)/sqrt2).
REQ-018 M(k,v) SHALL be full-precision signed product, arithmetic right shift by CF (floor), truncated to DW bits.
REQ-019 Additions/subtractions SHALL wrap modulo 2^DW; no saturation.
REQ-020 History registers s1_prev and d1_prev SHALL update with s1[n], d1[n] on each odd accept.
REQ-021 On odd accept, y2na<=s1[n], y2n_1<=x[2n+1], an/dn<=results; all visible after that same edge.
REQ-022 out_valid SHALL pulse high for the one cycle following each odd accept of pair n>=1; pair n=0 produces no output (an/dn hold, out_valid low).
REQ-023 x_valid low SHALL hold all state; gaps between samples of a pair are allowed.
REQ-024 Outputs SHALL hold their value between updates.

Reset
REQ-025 rst_n low SHALL asynchronously clear y2n, y2n_1, y2na, an, dn, out_valid, s1_prev, d1_prev to 0, phase to even, and first-pair flag set.
REQ-026 Reset mid-pair SHALL discard the pending even sample; next accept after release is even.
REQ-027 x_valid during reset SHALL be ignored.

Verification
REQ-028 All-zero input, 8 samples -> out_valid pulses 3 times, an=dn=0, y2na=0.
REQ-029 Constant x=16384, pair 0 -> y2n=y2n_1=16384, y2na=44762, out_valid stays low.
REQ-030 Constant x=16384, pair 1 -> an=23169, dn=-5790, out_valid one-cycle pulse; pair 2 and later -> an=23169, dn=5.
REQ-031 Apply 3 constant samples, assert rst_n low mid-stream, release, restart constant 16384 -> all outputs 0 during reset; pair-0/pair-1 sequence of REQ-029/030 repeats exactly.
REQ-032 x_valid toggled with random idle gaps on constant 16384 stream -> identical an/dn sequence to gap-free run, one out_valid pulse per odd accept after pair 0.
REQ-033 x=0x7FFFFFFF sustained -> results wrap per REQ-019, match bit-exact reference model of REQ-016..018.

Source files
------------

// File: rtl/lifting_block.sv
// Causal Daubechies-4 lifting forward transform.
// Samples arrive one at a time as even/odd pairs. Each odd sample completes a
// pair: the predict/update lifting steps run in one cycle and produce the
// approximation/detail pair for the previous pair index (a[n-1], d[n-1]).
// The first pair after reset only primes the history and emits no output.
module lifting_block #(
  parameter int unsigned DW = 32,  // sample and result width, two's complement
  parameter int unsigned CF = 14   // fraction bits of the Q2.CF coefficients
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] x_in,
  input  logic          x_valid,
  output logic [DW-1:0] y2n,
  output logic [DW-1:0] y2n_1,
  output logic [DW-1:0] y2na,
  output logic [DW-1:0] an,
  output logic [DW-1:0] dn,
  output logic          out_valid
);

  // Lifting coefficients in Q2.14
  localparam logic signed [15:0] K0 = 16'sd28378;  // sqrt3
  localparam logic signed [15:0] K1 = 16'sd7094;   // sqrt3/4
  localparam logic signed [15:0] K2 = -16'sd1098;  // (sqrt3-2)/4
  localparam logic signed [15:0] K3 = 16'sd8481;   // (sqrt3-1)/sqrt2
  localparam logic signed [15:0] K4 = 16'sd31651;  // (sqrt3+1)/sqrt2

  typedef enum logic {StEven, StOdd} phase_e;

  phase_e               phase_q;
  logic                 first_pair_q;
  logic signed [DW-1:0] y2n_q;
  logic signed [DW-1:0] y2n_1_q;
  logic signed [DW-1:0] y2na_q;
  logic signed [DW-1:0] an_q;
  logic signed [DW-1:0] dn_q;
  logic                 out_valid_q;
  logic signed [DW-1:0] s1_prev_q;
  logic signed [DW-1:0] d1_prev_q;

  logic signed [DW-1:0] s1_d;
  logic signed [DW-1:0] d1_d;
  logic signed [DW-1:0] s2_d;
  logic signed [DW-1:0] a_d;
  logic signed [DW-1:0] d_d;
  logic                 odd_accept;

  // Full-precision product, floor shift by CF, keep the low DW bits (wraps).
  function automatic logic signed [DW-1:0] coef_mul(input logic signed [15:0] k,
                                                    input logic signed [DW-1:0] v);
    logic signed [DW+15:0] k_ext;
    logic signed [DW+15:0] v_ext;
    logic signed [DW+15:0] prod;
    logic signed [DW+15:0] shifted;
    k_ext   = {{DW{k[15]}}, k};
    v_ext   = {{16{v[DW-1]}}, v};
    prod    = k_ext * v_ext;
    shifted = prod >>> CF;
    return shifted[DW-1:0];
  endfunction

  assign odd_accept = x_valid && (phase_q == StOdd);

  // Lifting datapath for the pair completed by the current odd sample
  always_comb begin
    s1_d = y2n_q + coef_mul(K0, x_in);
    d1_d = x_in - coef_mul(K1, s1_d) - coef_mul(K2, s1_prev_q);
    s2_d = s1_prev_q - d1_d;
    a_d  = coef_mul(K3, s2_d);
    d_d  = coef_mul(K4, d1_prev_q);
  end

  // Phase tracking, history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= StEven;
      first_pair_q <= 1'b1;
      y2n_q        <= '0;
      y2n_1_q      <= '0;
      y2na_q       <= '0;
      an_q         <= '0;
      dn_q         <= '0;
      out_valid_q  <= 1'b0;
      s1_prev_q    <= '0;
      d1_prev_q    <= '0;
    end else begin
      // Pair 0 only seeds the history, so it never raises out_valid
      out_valid_q <= odd_accept && !first_pair_q;
      if (x_valid) begin
        if (phase_q == StEven) begin
          y2n_q   <= x_in;
          phase_q <= StOdd;
        end else begin
          y2n_1_q      <= x_in;
          y2na_q       <= s1_d;
          s1_prev_q    <= s1_d;
          d1_prev_q    <= d1_d;
          phase_q      <= StEven;
          first_pair_q <= 1'b0;
          if (!first_pair_q) begin
            an_q <= a_d;
            dn_q <= d_d;
          end
        end
      end
    end
  end

  assign y2n       = y2n_q;
  assign y2n_1     = y2n_1_q;
  assign y2na      = y2na_q;
  assign an        = an_q;
  assign dn        = dn_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_lifting_block.sv
// Bench for lifting_block: stimulus pushes expected (an, dn) pairs into a
// scoreboard queue; an independent monitor pops and compares on out_valid.
module tb_lifting_block;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] x_in;
  logic          x_valid;
  logic [DW-1:0] y2n;
  logic [DW-1:0] y2n_1;
  logic [DW-1:0] y2na;
  logic [DW-1:0] an;
  logic [DW-1:0] dn;
  logic          out_valid;

  lifting_block #(.DW(DW), .CF(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .y2n       (y2n),
    .y2n_1     (y2n_1),
    .y2na      (y2na),
    .an        (an),
    .dn        (dn),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [2*DW-1:0] exp_q[$];
  logic prev_ov = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  // Monitor: compare every out_valid against the next scoreboard entry
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      logic [2*DW-1:0] e;
      pulse_cnt++;
      check("out_valid single-cycle", {31'd0, prev_ov}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected out_valid: an=%0d dn=%0d, no expected entry",
                 $signed(an), $signed(dn));
      end else begin
        e = exp_q.pop_front();
        check("an", an, e[2*DW-1:DW]);
        check("dn", dn, e[DW-1:0]);
      end
    end
    prev_ov = rst_n && out_valid;
  end

  // Independent reference: 64-bit product with explicit floor division
  function automatic int ref_mul(input int k, input int v);
    longint p;
    longint q;
    p = longint'(k) * longint'(v);
    q = p / 64'sd16384;
    if ((p % 64'sd16384) != 0 && p < 0) q = q - 1;
    return int'(q);
  endfunction

  task automatic send(input logic [DW-1:0] x, input int gap);
    x_in    = x;
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic push(input int a, input int d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " y2n"}, y2n, '0);
    check({tag, " y2n_1"}, y2n_1, '0);
    check({tag, " y2na"}, y2na, '0);
    check({tag, " an"}, an, '0);
    check({tag, " dn"}, dn, '0);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Reset with x_valid asserted to show it is ignored
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    x_in    = 32'd777;
    x_valid = 1'b1;
    rst_n   = 1'b0;
    #1;
    check_all_zero(tag);
    repeat (2) @(posedge clk);
    #2;
    check_all_zero(tag);
    rst_n   = 1'b1;
    x_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_and_check(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " scoreboard drained"}, exp_q.size(), 32'd0);
  endtask

  // Constant 16384 stream: pair 0 checks, then pairs 1..3 via scoreboard
  task automatic const_run(input string tag, input int max_gap);
    int p0;
    p0 = pulse_cnt;
    send(32'd16384, (max_gap > 0) ? $urandom_range(max_gap, 0) : 0);
    check({tag, " even y2n"}, y2n, 32'd16384);
    check({tag, " even y2n_1 held"}, y2n_1, 32'd0);
    check({tag, " even y2na held"}, y2na, 32'd0);
    x_in    = 32'd16384;
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    check({tag, " pair0 y2n_1"}, y2n_1, 32'd16384);
    check({tag, " pair0 y2na"}, y2na, 32'd44762);
    check({tag, " pair0 out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " pair0 an held"}, an, 32'd0);
    check({tag, " pair0 dn held"}, dn, 32'd0);
    if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(posedge clk);
    for (int n = 1; n <= 3; n++) begin
      if (n == 1) push(23169, -5790);
      else push(23169, 5);
      send(32'd16384, (max_gap > 0) ? $urandom_range(max_gap, 0) : 0);
      send(32'd16384, (max_gap > 0) ? $urandom_range(max_gap, 0) : 0);
    end
    drain_and_check(tag);
    check({tag, " pulse count"}, pulse_cnt - p0, 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int s1p, d1p, s1, d1, s2, xm;
    rst_n   = 1'b0;
    x_valid = 1'b0;
    x_in    = '0;
    #12;
    do_reset("reset");

    // All-zero input, 8 samples
    p0 = pulse_cnt;
    for (int n = 0; n < 4; n++) begin
      if (n > 0) push(0, 0);
      send(32'd0, 0);
      send(32'd0, 0);
    end
    drain_and_check("zero");
    check("zero pulse count", pulse_cnt - p0, 32'd3);
    check("zero y2na", y2na, 32'd0);

    do_reset("reset2");
    const_run("const", 0);

    // Reset in the middle of a pair, then the full sequence again
    do_reset("reset3");
    send(32'd16384, 0);
    send(32'd16384, 0);
    send(32'd16384, 0);
    check("midpair y2n before reset", y2n, 32'd16384);
    do_reset("midreset");
    const_run("restart", 0);

    // Random idle gaps between samples
    do_reset("reset4");
    const_run("gaps", 3);

    // Saturated positive input, checked against the reference model
    do_reset("reset5");
    xm  = 32'h7FFF_FFFF;
    s1p = 0;
    d1p = 0;
    p0  = pulse_cnt;
    for (int n = 0; n < 4; n++) begin
      s1 = xm + ref_mul(28378, xm);
      d1 = xm - ref_mul(7094, s1) - ref_mul(-1098, s1p);
      s2 = s1p - d1;
      if (n > 0) push(ref_mul(8481, s2), ref_mul(31651, d1p));
      s1p = s1;
      d1p = d1;
      send(xm, 0);
      send(xm, 0);
      check("max y2na", y2na, s1);
    end
    drain_and_check("max");
    check("max pulse count", pulse_cnt - p0, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
